// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: constants shared by the sync-FIFO read-side blocks.
//   WIDTH_FIFO_DEF / PACK_NUM_DEF : default byte width and bytes per packed word
//   ST_RUN / ST_FLUSH             : fifo_rd_pack control states
package sync_fifo_pkg;

  localparam int WIDTH_FIFO_DEF = 8;
  localparam int PACK_NUM_DEF   = 4;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/pack_acc.sv
// pack_acc: lane accumulator for fifo_rd_pack.
//   clk, rst : clock, synchronous active-high reset
//   wr       : a FIFO byte is present on wdata this cycle
//   wdata    : FIFO byte
//   take     : the current word (full or partial) leaves the accumulator
//   cnt      : number of bytes held (0..NUM)
//   lanes    : accumulated bytes, lane 0 oldest
module pack_acc import sync_fifo_pkg::*; #(
  parameter int WIDTH = WIDTH_FIFO_DEF,
  parameter int NUM   = PACK_NUM_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          take,
  output logic [$clog2(NUM+1)-1:0]      cnt,
  output logic [NUM-1:0][WIDTH-1:0]     lanes
);

  localparam int CW = $clog2(NUM+1);

  // A byte arriving while an already-full word leaves starts the next word.
  logic spill;
  assign spill = wr && take && (cnt == CW'(NUM));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      lanes <= '0;
    end else begin
      if (take)
        cnt <= spill ? CW'(1) : '0;
      else if (wr && cnt != CW'(NUM))
        cnt <= cnt + 1'b1;

      for (int i = 0; i < NUM; i++) begin
        if (spill ? (i == 0) : (wr && cnt == CW'(i)))
          lanes[i] <= wdata;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_pack.sv
// fifo_rd_pack: reads bytes from a sync FIFO (1-cycle read latency) and packs
// PACK_NUM of them into one output word, lane 0 oldest.
//   clk, rst               : clock, synchronous active-high reset
//   fifo_empty/fifo_ren    : upstream FIFO flag and read strobe
//   fifo_rdata             : byte valid the cycle after an accepted read
//   flush / flush_done     : emit partial word request / completion pulse
//   out_valid/out_ready    : output handshake
//   out_data / out_keep    : packed word and per-lane valid mask
module fifo_rd_pack import sync_fifo_pkg::*; #(
  parameter  int WIDTH_FIFO = WIDTH_FIFO_DEF,
  parameter  int PACK_NUM   = PACK_NUM_DEF,
  localparam int OUT_WIDTH  = WIDTH_FIFO*PACK_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [WIDTH_FIFO-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [PACK_NUM-1:0]   out_keep
);

  localparam int             CW       = $clog2(PACK_NUM+1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(PACK_NUM);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PACK_NUM-1);

  logic [0:0]                          state;
  logic                                pend;
  logic [CW-1:0]                       cnt;
  logic [PACK_NUM-1:0][WIDTH_FIFO-1:0] lanes, word_full, word_part;
  logic [PACK_NUM-1:0]                 keep_part;
  logic [CW:0]                         inflight;
  logic                                slot_free, word_move, flush_cmp, part_load;

  assign slot_free = !out_valid || out_ready;
  // Full word is ready either already accumulated or completing with this cycle's byte.
  assign word_move = slot_free && (cnt == CNT_FULL || (cnt == CNT_LAST && pend));
  assign flush_cmp = (state == ST_FLUSH) && !pend && slot_free;
  assign part_load = flush_cmp && cnt != '0 && cnt != CNT_FULL;

  // Bytes held plus the one in flight must leave room, unless a word drains now.
  assign inflight = {1'b0, cnt} + {{CW{1'b0}}, pend};
  assign fifo_ren = !rst && !fifo_empty && (state == ST_RUN) &&
                    (inflight < (CW+1)'(PACK_NUM) || word_move);

  always_comb begin
    word_full = lanes;
    word_part = '0;
    keep_part = '0;
    if (pend && cnt == CNT_LAST) word_full[PACK_NUM-1] = fifo_rdata;
    for (int i = 0; i < PACK_NUM; i++) begin
      if (CW'(i) < cnt) begin
        word_part[i] = lanes[i];
        keep_part[i] = 1'b1;
      end
    end
  end

  pack_acc #(.WIDTH(WIDTH_FIFO), .NUM(PACK_NUM)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .wr    (pend),
    .wdata (fifo_rdata),
    .take  (word_move || part_load),
    .cnt   (cnt),
    .lanes (lanes)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pend       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      flush_done <= 1'b0;
    end else begin
      pend       <= fifo_ren;
      flush_done <= flush_cmp;

      if (word_move) begin
        out_data  <= word_full;
        out_keep  <= '1;
        out_valid <= 1'b1;
      end else if (part_load) begin
        out_data  <= word_part;
        out_keep  <= keep_part;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (state == ST_RUN) begin
        if (flush) state <= ST_FLUSH;
      end else if (flush_cmp) begin
        state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_pack.sv
// tb_fifo_rd_pack: scoreboard bench for fifo_rd_pack. The reference model
// groups the pushed byte stream into PACK_NUM-byte words; a flush closes the
// current group as a partial word; reset discards the open group.
module tb_fifo_rd_pack;
  localparam int W  = 8;
  localparam int P  = 4;
  localparam int OW = W*P;

  logic          clk = 1'b0;
  logic          rst, fifo_empty, fifo_ren, flush, flush_done, out_valid, out_ready;
  logic [W-1:0]  fifo_rdata;
  logic [OW-1:0] out_data;
  logic [P-1:0]  out_keep;

  fifo_rd_pack #(.WIDTH_FIFO(W), .PACK_NUM(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .fifo_rdata (fifo_rdata),
    .flush      (flush),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [P-1:0]  keep;
  } word_t;

  word_t        exp_q[$];
  logic [W-1:0] fq[$];      // upstream FIFO contents
  logic [W-1:0] cur[$];     // bytes of the word being formed
  logic [W-1:0] push_q[$];  // bytes to enter the FIFO at the next tick
  int n_chk = 0, n_fail = 0;
  int rd_total = 0, words_out = 0, done_seen = 0, done_exp = 0;
  int ren_run = 0, ren_run_max = 0;
  logic last_ren = 1'b0;

  task automatic fail(input string name, input logic [63:0] got, input logic [63:0] want);
    n_fail++;
    $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) fail(name, got, want);
  endtask

  function automatic word_t mk_word();
    word_t w;
    w = '0;
    for (int i = 0; i < cur.size(); i++) begin
      w.data[i*W +: W] = cur[i];
      w.keep[i]        = 1'b1;
    end
    return w;
  endfunction

  task automatic model_byte(input logic [W-1:0] b);
    cur.push_back(b);
    if (cur.size() == P) begin
      exp_q.push_back(mk_word());
      cur.delete();
    end
  endtask

  task automatic model_flush();
    if (cur.size() > 0) begin
      exp_q.push_back(mk_word());
      cur.delete();
    end
    done_exp++;
  endtask

  // One clock: inputs change at the falling edge, ren sampled 1 later,
  // outputs checked by the monitor 2 later; returns after both.
  task automatic tick(input logic rdy, input logic fl, input logic rs);
    logic [W-1:0] b;
    @(negedge clk);
    if (last_ren) begin
      if (fq.size() == 0) fail("fifo_underflow", 0, 1);
      else fifo_rdata = fq.pop_front();
    end
    out_ready = rdy;
    rst       = rs;
    if (rs) begin
      fq.delete(); cur.delete(); exp_q.delete(); push_q.delete();
    end
    while (push_q.size() > 0) begin
      b = push_q.pop_front();
      fq.push_back(b);
      model_byte(b);
    end
    flush = fl;
    if (fl) model_flush();
    fifo_empty = (fq.size() == 0);
    #1;
    n_chk++;
    if (fifo_ren && (fifo_empty || rst)) fail("ren_guard", {fifo_empty, rst}, 0);
    last_ren = fifo_ren;
    if (fifo_ren) begin
      rd_total++;
      ren_run++;
      if (ren_run > ren_run_max) ren_run_max = ren_run;
    end else begin
      ren_run = 0;
    end
    #2;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(rdy, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    int base, k;
    base = done_seen;
    k = 0;
    while (fq.size() != 0 && k < 100) begin tick(1'b1, 1'b0, 1'b0); k++; end
    tick(1'b1, 1'b1, 1'b0);
    k = 0;
    while (done_seen == base && k < 20) begin tick(1'b1, 1'b0, 1'b0); k++; end
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("flush_done_once", done_seen, base + 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && k < 300) begin
      tick(1'b1, 1'b0, 1'b0); k++;
    end
    chk("drain_exp_left", exp_q.size(), 0);
    chk("drain_fifo_left", fq.size(), 0);
  endtask

  // Monitor: every valid cycle must show the scoreboard head; pop on accept.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst !== 1'b1) begin
      if (flush_done) done_seen++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          fail("spurious_word", out_data, 0);
        end else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_keep", out_keep, exp_q[0].keep);
          if (out_ready) begin
            void'(exp_q.pop_front());
            words_out++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;
    rst = 1'b1; fifo_empty = 1'b1; fifo_rdata = '0; flush = 1'b0; out_ready = 1'b0;

    // reset state
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_keep", out_keep, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flush_done", flush_done, 0);

    // four bytes make one full word
    w0 = words_out;
    push_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run(12, 1'b1);
    chk("word_0x44332211_count", words_out - w0, 1);

    // eight queued bytes stream back to back
    w0 = words_out; ren_run_max = 0;
    for (int i = 0; i < 8; i++) push_q.push_back(W'($urandom));
    run(16, 1'b1);
    chk("ren_consecutive", ren_run_max, 8);
    chk("two_words", words_out - w0, 2);

    // backpressure: absorb 2*P bytes then stall, then drain the rest
    w0 = words_out; r0 = rd_total;
    for (int i = 0; i < 12; i++) push_q.push_back(W'($urandom));
    run(30, 1'b0);
    chk("stall_reads", rd_total - r0, 2*P);
    chk("stall_fifo_left", fq.size(), 4);
    run(30, 1'b1);
    chk("stall_words", words_out - w0, 3);

    // partial flush
    w0 = words_out;
    push_q = '{8'hA1, 8'hB2, 8'hC3};
    run(8, 1'b1);
    do_flush();
    chk("partial_word_count", words_out - w0, 1);

    // flush with nothing held
    w0 = words_out;
    do_flush();
    chk("empty_flush_no_word", words_out - w0, 0);

    // reset with cnt=2 and a read in flight, then a clean word
    push_q = '{8'h5A, 8'h6B, 8'h7C};
    run(3, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    w0 = words_out;
    push_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run(12, 1'b1);
    chk("post_reset_word_count", words_out - w0, 1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        tick(1'b1, 1'b0, 1'b1);
      end else if (r < 5) begin
        do_flush();
      end else begin
        if (fq.size() < 12) begin
          int n;
          n = $urandom_range(0, 2);
          for (int i = 0; i < n; i++) push_q.push_back(W'($urandom));
        end
        tick($urandom_range(0, 3) != 0, 1'b0, 1'b0);
      end
    end
    do_flush();
    drain();
    chk("flush_done_total", done_seen, done_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
